// File: rtl/scalable_border_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : scalable_border_seq_detector
// Brief    : Bit-serial detector for a runtime-loadable SEQ_LEN-bit pattern.
//            Uses longest-prefix/suffix fallback so that no partial match is
//            lost. Supports an input qualifier, overlapping or non-overlapping
//            detection, and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module scalable_border_seq_detector #(
    parameter int SEQ_LEN    = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int STATE_BITS = $clog2(SEQ_LEN)
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SEQ_LEN-1:0]    sequence_str,
    input  logic                  overlap_en,
    input  logic                  x_valid,
    input  logic                  x,
    input  logic                  count_clr,
    output logic [STATE_BITS-1:0] curr_state,
    output logic                  match,
    output logic [CNT_WIDTH-1:0]  match_cnt,
    output logic                  hist_full
);

    localparam logic [STATE_BITS-1:0] c_hist_max = STATE_BITS'(SEQ_LEN - 1);
    localparam logic [STATE_BITS-1:0] c_hist_one = STATE_BITS'(1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max  = '1;
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = CNT_WIDTH'(1);

    // Registered state
    logic [SEQ_LEN-1:0]    pattern_q,   pattern_d;
    logic [SEQ_LEN-2:0]    history_q,   history_d;
    logic [STATE_BITS-1:0] hist_cnt_q,  hist_cnt_d;
    logic [STATE_BITS-1:0] curr_state_q, curr_state_d;
    logic                  match_q,     match_d;
    logic [CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d;
    logic                  hist_full_q, hist_full_d;

    // Window of the newest SEQ_LEN bits, newest (the incoming x) at bit 0
    logic [SEQ_LEN-1:0]    w_window;
    // w_cand[k-1] is set when a prefix of length k matches the window tail
    logic [SEQ_LEN-1:0]    w_cand;
    logic                  w_full;
    logic [STATE_BITS-1:0] w_best;

    assign w_window = {history_q, x};
    assign w_full   = w_cand[SEQ_LEN-1];

    // One comparator per candidate prefix length k = 1..SEQ_LEN. The newest
    // bit of the window lines up with pattern[k-1], the oldest with pattern[0].
    generate
        for (genvar gk = 1; gk <= SEQ_LEN; gk++) begin : g_cand
            logic [gk-1:0] w_bit_eq;
            logic          w_avail;

            for (genvar gj = 0; gj < gk; gj++) begin : g_bit
                assign w_bit_eq[gj] = (w_window[gj] == pattern_q[gk-1-gj]);
            end

            // A length-k candidate is only valid once k bits have been seen
            if (gk == 1) begin : g_first
                assign w_avail = 1'b1;
            end else begin : g_rest
                assign w_avail = (hist_cnt_q >= STATE_BITS'(gk - 1));
            end

            assign w_cand[gk-1] = (&w_bit_eq) & w_avail;
        end
    endgenerate

    // Priority pick of the longest proper prefix that matches; this is both
    // the new state on a partial match and the border after a full match
    always_comb begin
        w_best = '0;
        for (int i = 1; i < SEQ_LEN; i++) begin
            if (w_cand[i-1]) begin
                w_best = STATE_BITS'(i);
            end
        end
    end

    // Next-state computation: load first, then bit consumption, then clear
    always_comb begin
        pattern_d    = pattern_q;
        history_d    = history_q;
        hist_cnt_d   = hist_cnt_q;
        curr_state_d = curr_state_q;
        match_d      = 1'b0;
        match_cnt_d  = match_cnt_q;

        if (load) begin
            pattern_d    = sequence_str;
            history_d    = '0;
            hist_cnt_d   = '0;
            curr_state_d = '0;
            match_cnt_d  = '0;
        end else begin
            if (x_valid) begin
                curr_state_d = w_best;
                history_d    = w_window[SEQ_LEN-2:0];
                if (hist_cnt_q != c_hist_max) begin
                    hist_cnt_d = hist_cnt_q + c_hist_one;
                end
                if (w_full) begin
                    match_d = 1'b1;
                    if (match_cnt_q != c_cnt_max) begin
                        match_cnt_d = match_cnt_q + c_cnt_one;
                    end
                    // Non-overlapping: the matched bits may not be reused
                    if (!overlap_en) begin
                        history_d    = '0;
                        hist_cnt_d   = '0;
                        curr_state_d = '0;
                    end
                end
            end
            if (count_clr) begin
                match_cnt_d = '0;
            end
        end

        hist_full_d = (hist_cnt_d == c_hist_max);
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            pattern_q    <= '0;
            history_q    <= '0;
            hist_cnt_q   <= '0;
            curr_state_q <= '0;
            match_q      <= 1'b0;
            match_cnt_q  <= '0;
            hist_full_q  <= 1'b0;
        end else begin
            pattern_q    <= pattern_d;
            history_q    <= history_d;
            hist_cnt_q   <= hist_cnt_d;
            curr_state_q <= curr_state_d;
            match_q      <= match_d;
            match_cnt_q  <= match_cnt_d;
            hist_full_q  <= hist_full_d;
        end
    end

    assign curr_state = curr_state_q;
    assign match      = match_q;
    assign match_cnt  = match_cnt_q;
    assign hist_full  = hist_full_q;

endmodule
`default_nettype wire

// File: tb/tb_scalable_border_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_scalable_border_seq_detector
// Brief    : Directed self-checking bench for scalable_border_seq_detector
//            with SEQ_LEN=4 and a 2-bit match counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scalable_border_seq_detector;

    localparam int SEQ_LEN   = 4;
    localparam int CNT_WIDTH = 2;

    logic               clock0;
    logic               reset;
    logic               load;
    logic [SEQ_LEN-1:0] sequence_str;
    logic               overlap_en;
    logic               x_valid;
    logic               x;
    logic               count_clr;
    logic [1:0]         curr_state;
    logic               match;
    logic [1:0]         match_cnt;
    logic               hist_full;

    int n_checks = 0;
    int n_fail   = 0;

    scalable_border_seq_detector #(
        .SEQ_LEN   (SEQ_LEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock0       (clock0),
        .reset        (reset),
        .load         (load),
        .sequence_str (sequence_str),
        .overlap_en   (overlap_en),
        .x_valid      (x_valid),
        .x            (x),
        .count_clr    (count_clr),
        .curr_state   (curr_state),
        .match        (match),
        .match_cnt    (match_cnt),
        .hist_full    (hist_full)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    // One clock with the given qualifier and bit; outputs sampled 1ns later
    task automatic step(input logic b, input logic v);
        x       = b;
        x_valid = v;
        @(posedge clock0);
        #1;
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] p);
        load         = 1'b1;
        sequence_str = p;
        @(posedge clock0);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++; if (curr_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", curr_state); end
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0d expected 0", match); end
        n_checks++; if (match_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        n_checks++; if (hist_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0d expected 0", hist_full); end
        reset = 1'b0;
        @(posedge clock0);
        #1;
    endtask

    // Pattern 1,1,0,1 with overlap: borders let bit 7 complete a second match
    task automatic test_overlap();
        logic       s  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] es [7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
        logic       em [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic       ef [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        overlap_en = 1'b1;
        do_load(4'b1011);
        n_checks++; if (curr_state !== 2'd0) begin n_fail++; $display("FAIL load_state: got %0d expected 0", curr_state); end
        for (int i = 0; i < 7; i++) begin
            step(s[i], 1'b1);
            n_checks++; if (curr_state !== es[i]) begin n_fail++; $display("FAIL ovl_state bit%0d: got %0d expected %0d", i+1, curr_state, es[i]); end
            n_checks++; if (match !== em[i]) begin n_fail++; $display("FAIL ovl_match bit%0d: got %0d expected %0d", i+1, match, em[i]); end
            n_checks++; if (match_cnt !== ec[i]) begin n_fail++; $display("FAIL ovl_cnt bit%0d: got %0d expected %0d", i+1, match_cnt, ec[i]); end
            n_checks++; if (hist_full !== ef[i]) begin n_fail++; $display("FAIL ovl_full bit%0d: got %0d expected %0d", i+1, hist_full, ef[i]); end
        end
    endtask

    // Same stream without overlap: history is flushed after bit 4, so bits
    // 5..7 (1,0,1) are matched from scratch giving states 1,0,1
    task automatic test_no_overlap();
        logic       s  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] es [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
        logic       em [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        logic       ef [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        overlap_en = 1'b0;
        do_load(4'b1011);
        for (int i = 0; i < 7; i++) begin
            step(s[i], 1'b1);
            n_checks++; if (curr_state !== es[i]) begin n_fail++; $display("FAIL novl_state bit%0d: got %0d expected %0d", i+1, curr_state, es[i]); end
            n_checks++; if (match !== em[i]) begin n_fail++; $display("FAIL novl_match bit%0d: got %0d expected %0d", i+1, match, em[i]); end
            n_checks++; if (match_cnt !== ec[i]) begin n_fail++; $display("FAIL novl_cnt bit%0d: got %0d expected %0d", i+1, match_cnt, ec[i]); end
            n_checks++; if (hist_full !== ef[i]) begin n_fail++; $display("FAIL novl_full bit%0d: got %0d expected %0d", i+1, hist_full, ef[i]); end
        end
    endtask

    // Mismatches fall back to the longest border instead of state 0
    task automatic test_fallback();
        logic       s  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] es [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
        logic       em [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        overlap_en = 1'b1;
        do_load(4'b1011);
        for (int i = 0; i < 5; i++) begin
            step(s[i], 1'b1);
            n_checks++; if (curr_state !== es[i]) begin n_fail++; $display("FAIL fb_state bit%0d: got %0d expected %0d", i+1, curr_state, es[i]); end
            n_checks++; if (match !== em[i]) begin n_fail++; $display("FAIL fb_match bit%0d: got %0d expected %0d", i+1, match, em[i]); end
        end
    endtask

    // Idle cycles between bits keep the partial match alive
    task automatic test_gaps();
        overlap_en = 1'b1;
        do_load(4'b1011);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            n_checks++; if (curr_state !== 2'd2) begin n_fail++; $display("FAIL gap_state idle%0d: got %0d expected 2", i, curr_state); end
            n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL gap_match idle%0d: got %0d expected 0", i, match); end
        end
        step(1'b0, 1'b1);
        n_checks++; if (curr_state !== 2'd3) begin n_fail++; $display("FAIL gap_state3: got %0d expected 3", curr_state); end
        step(1'b1, 1'b1);
        n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL gap_match_end: got %0d expected 1", match); end
        n_checks++; if (curr_state !== 2'd1) begin n_fail++; $display("FAIL gap_border: got %0d expected 1", curr_state); end
        step(1'b0, 1'b0);
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL gap_pulse_width: got %0d expected 0", match); end
        n_checks++; if (curr_state !== 2'd1) begin n_fail++; $display("FAIL gap_hold: got %0d expected 1", curr_state); end
    endtask

    // Pattern 1111 matches every cycle once primed; counter saturates at 3
    task automatic test_back_to_back();
        logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        overlap_en = 1'b1;
        do_load(4'b1111);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        n_checks++; if (curr_state !== 2'd3) begin n_fail++; $display("FAIL b2b_prime: got %0d expected 3", curr_state); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL b2b_match m%0d: got %0d expected 1", i+1, match); end
            n_checks++; if (match_cnt !== ec[i]) begin n_fail++; $display("FAIL b2b_cnt m%0d: got %0d expected %0d", i+1, match_cnt, ec[i]); end
            n_checks++; if (curr_state !== 2'd3) begin n_fail++; $display("FAIL b2b_state m%0d: got %0d expected 3", i+1, curr_state); end
        end
        count_clr = 1'b1;
        step(1'b1, 1'b1);
        count_clr = 1'b0;
        n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL clr_match: got %0d expected 1", match); end
        n_checks++; if (match_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_wins: got %0d expected 0", match_cnt); end
        step(1'b1, 1'b1);
        n_checks++; if (match_cnt !== 2'd1) begin n_fail++; $display("FAIL clr_resume: got %0d expected 1", match_cnt); end
        count_clr = 1'b1;
        step(1'b0, 1'b0);
        count_clr = 1'b0;
        n_checks++; if (match_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_idle: got %0d expected 0", match_cnt); end
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL clr_idle_match: got %0d expected 0", match); end
    endtask

    // Load while a match would complete: bit discarded, no pulse, all cleared
    task automatic test_load_discard();
        overlap_en = 1'b1;
        do_load(4'b1011);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        n_checks++; if (curr_state !== 2'd3 || match_cnt !== 2'd1) begin n_fail++; $display("FAIL ld_pre: got state %0d cnt %0d expected 3 1", curr_state, match_cnt); end
        load         = 1'b1;
        sequence_str = 4'b1011;
        x_valid      = 1'b1;
        x            = 1'b1;
        @(posedge clock0);
        #1;
        load    = 1'b0;
        x_valid = 1'b0;
        x       = 1'b0;
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL ld_match: got %0d expected 0", match); end
        n_checks++; if (curr_state !== 2'd0) begin n_fail++; $display("FAIL ld_state: got %0d expected 0", curr_state); end
        n_checks++; if (match_cnt !== 2'd0) begin n_fail++; $display("FAIL ld_cnt: got %0d expected 0", match_cnt); end
        n_checks++; if (hist_full !== 1'b0) begin n_fail++; $display("FAIL ld_full: got %0d expected 0", hist_full); end
        step(1'b1, 1'b1);
        n_checks++; if (curr_state !== 2'd1) begin n_fail++; $display("FAIL ld_after1: got %0d expected 1", curr_state); end
        step(1'b1, 1'b1);
        n_checks++; if (curr_state !== 2'd2) begin n_fail++; $display("FAIL ld_after2: got %0d expected 2", curr_state); end
    endtask

    // Reset between clock edges clears outputs immediately and the pattern
    task automatic test_async_reset();
        overlap_en = 1'b1;
        do_load(4'b1011);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        n_checks++; if (curr_state !== 2'd3) begin n_fail++; $display("FAIL ar_pre: got %0d expected 3", curr_state); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (curr_state !== 2'd0) begin n_fail++; $display("FAIL ar_state: got %0d expected 0", curr_state); end
        n_checks++; if (match_cnt !== 2'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d expected 0", match_cnt); end
        n_checks++; if (hist_full !== 1'b0) begin n_fail++; $display("FAIL ar_full: got %0d expected 0", hist_full); end
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL ar_match: got %0d expected 0", match); end
        #1;
        reset = 1'b0;
        // Pattern is now 0000: a 1 matches nothing, a following 0 matches length 1
        step(1'b1, 1'b1);
        n_checks++; if (curr_state !== 2'd0) begin n_fail++; $display("FAIL ar_post1: got %0d expected 0", curr_state); end
        step(1'b0, 1'b1);
        n_checks++; if (curr_state !== 2'd1) begin n_fail++; $display("FAIL ar_post2: got %0d expected 1", curr_state); end
    endtask

    initial begin
        reset        = 1'b0;
        load         = 1'b0;
        sequence_str = '0;
        overlap_en   = 1'b0;
        x_valid      = 1'b0;
        x            = 1'b0;
        count_clr    = 1'b0;
        test_reset();
        test_overlap();
        test_no_overlap();
        test_fallback();
        test_gaps();
        test_back_to_back();
        test_load_discard();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
